// File: rtl/mux_2by1_pkg.sv
// Shared defaults for the registered 2:1 steering mux.
package mux_2by1_pkg;
  localparam int MUX_WIDTH_DEF   = 4;
  localparam bit MUX_REG_OUT_DEF = 1'b1;
endpackage

// File: rtl/mux_2by1_core.sv
// Combinational WIDTH-bit 2:1 select; one bit-slice per generate iteration.
module mux2_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I0,
  input  logic             S0,
  output logic [WIDTH-1:0] Y
);
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    assign Y[b] = S0 ? I1[b] : I0[b];
  end
endmodule

// File: rtl/mux_2by1.sv
// 2:1 mux with generate-selected output stage: registered (sync reset) or direct.
module mux_2by1
  import mux_2by1_pkg::*;
#(
  parameter int WIDTH   = MUX_WIDTH_DEF,
  parameter bit REG_OUT = MUX_REG_OUT_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I0,
  input  logic             S0,
  output logic [WIDTH-1:0] DVal
);
  logic [WIDTH-1:0] sel;

  mux2_core #(.WIDTH(WIDTH)) u_core (
    .I1 (I1),
    .I0 (I0),
    .S0 (S0),
    .Y  (sel)
  );

  if (REG_OUT) begin : g_reg
    // Reset wins over the data path; register reloads every edge.
    always_ff @(posedge Clk) begin
      if (Rst) DVal <= '0;
      else     DVal <= sel;
    end
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = Clk ^ Rst;
    assign DVal = sel;
  end
endmodule

// File: tb/tb_mux_2by1.sv
// Directed bench for mux_2by1: registered instance plus a combinational instance.
module tb_mux_2by1;
  logic       Clk = 1'b0;
  logic       Rst;
  logic [3:0] I1, I0;
  logic       S0;
  logic [3:0] DVal;

  logic [3:0] c_i1, c_i0;
  logic       c_s0;
  logic [3:0] c_dval;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  mux_2by1 #(.WIDTH(4), .REG_OUT(1'b1)) dut_reg (
    .Clk(Clk), .Rst(Rst), .I1(I1), .I0(I0), .S0(S0), .DVal(DVal)
  );

  mux_2by1 #(.WIDTH(4), .REG_OUT(1'b0)) dut_comb (
    .Clk(Clk), .Rst(Rst), .I1(c_i1), .I0(c_i0), .S0(c_s0), .DVal(c_dval)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; I1 = 4'b1111; I0 = 4'b1010; S0 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (DVal !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_cyc%0d: got %b want 0000", i, DVal);
      end
    end
  endtask

  task automatic test_select();
    Rst = 1'b0; S0 = 1'b0; I1 = 4'b0001; I0 = 4'b0000;
    tick();
    vectors++;
    if (DVal !== 4'b0000) begin
      miscompares++;
      $display("FAIL select0: got %b want 0000", DVal);
    end
    S0 = 1'b1;
    #1;
    vectors++;
    if (DVal !== 4'b0000) begin
      miscompares++;
      $display("FAIL select1_pre_edge: got %b want 0000", DVal);
    end
    tick();
    vectors++;
    if (DVal !== 4'b0001) begin
      miscompares++;
      $display("FAIL select1: got %b want 0001", DVal);
    end
  endtask

  task automatic test_toggle();
    logic [3:0] exp, prev;
    I1 = 4'b1100; I0 = 4'b0011; S0 = 1'b0;
    tick();
    prev = 4'b0011;
    for (int i = 0; i < 6; i++) begin
      S0 = ~S0;
      #1;
      vectors++;
      if (DVal !== prev) begin
        miscompares++;
        $display("FAIL toggle_hold%0d: got %b want %b", i, DVal, prev);
      end
      exp = S0 ? 4'b1100 : 4'b0011;
      tick();
      vectors++;
      if (DVal !== exp) begin
        miscompares++;
        $display("FAIL toggle%0d: got %b want %b", i, DVal, exp);
      end
      prev = exp;
    end
  endtask

  task automatic test_midstream_reset();
    S0 = 1'b1; I1 = 4'b0101; I0 = 4'b1110;
    tick();
    vectors++;
    if (DVal !== 4'b0101) begin
      miscompares++;
      $display("FAIL mid_pre: got %b want 0101", DVal);
    end
    Rst = 1'b1;
    tick();
    vectors++;
    if (DVal !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_rst: got %b want 0000", DVal);
    end
    Rst = 1'b0;
    tick();
    vectors++;
    if (DVal !== 4'b0101) begin
      miscompares++;
      $display("FAIL mid_resume: got %b want 0101", DVal);
    end
  endtask

  task automatic test_back_to_back();
    // Data and select change together each cycle.
    logic [3:0] v1 [4] = '{4'b1000, 4'b0110, 4'b1111, 4'b0010};
    logic [3:0] v0 [4] = '{4'b0111, 4'b1001, 4'b0000, 4'b1101};
    logic       vs [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] exp;
    for (int i = 0; i < 4; i++) begin
      I1 = v1[i]; I0 = v0[i]; S0 = vs[i];
      exp = vs[i] ? v1[i] : v0[i];
      tick();
      vectors++;
      if (DVal !== exp) begin
        miscompares++;
        $display("FAIL b2b%0d: got %b want %b", i, DVal, exp);
      end
    end
  endtask

  task automatic test_comb();
    c_s0 = 1'b1; c_i1 = 4'b1001; c_i0 = 4'b0000;
    #1;
    vectors++;
    if (c_dval !== 4'b1001) begin
      miscompares++;
      $display("FAIL comb_s1: got %b want 1001", c_dval);
    end
    c_s0 = 1'b0; c_i0 = 4'b0110;
    #1;
    vectors++;
    if (c_dval !== 4'b0110) begin
      miscompares++;
      $display("FAIL comb_s0: got %b want 0110", c_dval);
    end
    c_i1 = 4'b1010; c_i0 = 4'b0101; c_s0 = 1'b1;
    #1;
    vectors++;
    if (c_dval !== 4'b1010) begin
      miscompares++;
      $display("FAIL comb_mix1: got %b want 1010", c_dval);
    end
    c_s0 = 1'b0;
    #1;
    vectors++;
    if (c_dval !== 4'b0101) begin
      miscompares++;
      $display("FAIL comb_mix0: got %b want 0101", c_dval);
    end
  endtask

  initial begin
    Rst = 1'b1; I1 = '0; I0 = '0; S0 = 1'b0;
    c_i1 = '0; c_i0 = '0; c_s0 = 1'b0;
    test_reset();
    test_select();
    test_toggle();
    test_midstream_reset();
    test_back_to_back();
    test_comb();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
